// File: rtl/pdm_capture.sv
// Purpose: clocks a PDM mic while enabled, decimates the bit stream by ones-count into PCM words with memory indices.
// Latency: first word valid 2*HALF_PERIOD*(WARMUP_BITS+WINDOW) cycles after capture starts, then every 2*HALF_PERIOD*WINDOW.
// Backpressure: none; sample_valid_o is a write strobe the memory must accept, enable_i low aborts at once.
module pdm_capture #(
    parameter int HALF_PERIOD = 50,
    parameter int WARMUP_BITS = 1024,
    parameter int WINDOW      = 256,
    parameter int SAMPLE_W    = 8,
    parameter int ADDR_W      = 17,
    parameter int NUM_SAMPLES = 131072
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    output logic                done_o,
    output logic                mic_clk_o,
    input  logic                mic_data_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic [ADDR_W-1:0]   sample_index_o,
    output logic                sample_valid_o
);

    localparam int DIV_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int CNT_MAX    = (WARMUP_BITS > WINDOW) ? WARMUP_BITS : WINDOW;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int ACC_W      = $clog2(WINDOW + 1);
    localparam int SAMPLE_MAX = (1 << SAMPLE_W) - 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP_BITS - 1);
    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic                mic_clk;
    logic [1:0]          sync;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [SAMPLE_W-1:0] sample_sat;
    logic [SAMPLE_W-1:0] sample;
    logic [ADDR_W-1:0]   index;
    logic                valid;
    logic                active, sample_pt, warm_done, win_done, last_word;

    assign active    = (state == WARMUP) || (state == RUN);
    // Last divider count with the mic clock high: the bit is stable just before the falling edge.
    assign sample_pt = active && (div_cnt == DIV_LAST) && mic_clk;
    assign warm_done = (state == WARMUP) && sample_pt && (bit_cnt == WARM_LAST);
    assign win_done  = (state == RUN) && sample_pt && (bit_cnt == WIN_LAST) && enable_i;
    assign last_word = valid && (index == IDX_LAST);
    assign acc_sum   = acc + ACC_W'(sync[1]);

    // Saturate the window count (including the current bit) to the PCM word width.
    always_comb begin
        sample_sat = SAMPLE_W'(acc_sum);
        if (32'(acc_sum) > SAMPLE_MAX) begin
            sample_sat = '1;
        end
    end

    // Next-state logic; enable low always wins and returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i)  state_nxt = WARMUP;
            WARMUP:  if (warm_done) state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (!enable_i) begin
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Two-flop synchronizer for the asynchronous mic data.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], mic_data_i};
        end
    end

    // Mic clock divider: parked at zero outside capture, free-running across WARMUP->RUN.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if ((state_nxt == IDLE) || (state_nxt == DONE)) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                mic_clk <= ~mic_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Bit counter (warmup bits, then bits within a window) and ones accumulator.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (state_nxt != state) begin
            bit_cnt <= '0;
            acc     <= '0;
        end else if (sample_pt) begin
            if ((state == RUN) && (bit_cnt == WIN_LAST)) begin
                bit_cnt <= '0;
                acc     <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (state == RUN) begin
                    acc <= acc_sum;
                end
            end
        end
    end

    // Output word, write strobe and memory index; index holds at the last word in DONE.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sample <= '0;
            valid  <= 1'b0;
            index  <= '0;
        end else begin
            valid <= win_done;
            if (win_done) begin
                sample <= sample_sat;
            end
            if (state == IDLE) begin
                index <= '0;
            end else if (valid && !last_word) begin
                index <= index + ADDR_W'(1);
            end
        end
    end

    assign done_o         = (state == DONE);
    assign mic_clk_o      = mic_clk;
    assign sample_o       = sample;
    assign sample_index_o = index;
    assign sample_valid_o = valid;

endmodule

// File: tb/tb_pdm_capture.sv
// Purpose: exercises two pdm_capture configurations (short window with a 3-word clip, 256-bit window) against a bit-level model.
// Latency: expected pulse cycles and word values come from the window/warmup arithmetic, not from the RTL structure.
// Backpressure: none; the bench only drives enable, reset and mic data.
module tb_pdm_capture;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en_a, en_b, dat_a, dat_b;
    logic       done_a, done_b, mic_a, mic_b, valid_a, valid_b;
    logic [7:0] sample_a, sample_b;
    logic [3:0] index_a;
    logic [16:0] index_b;

    int checks   = 0;
    int failures = 0;
    int mode_a   = 1;
    int mode_b   = 1;
    int bitno_a  = 0;
    int bitno_b  = 0;
    logic rnd [0:63];

    always #5 clk = ~clk;

    pdm_capture #(
        .HALF_PERIOD(2), .WARMUP_BITS(4), .WINDOW(8), .SAMPLE_W(8), .ADDR_W(4), .NUM_SAMPLES(3)
    ) dut_a (
        .clock_i(clk), .reset_i(reset_n), .enable_i(en_a), .done_o(done_a), .mic_clk_o(mic_a),
        .mic_data_i(dat_a), .sample_o(sample_a), .sample_index_o(index_a), .sample_valid_o(valid_a)
    );

    pdm_capture #(
        .HALF_PERIOD(2), .WARMUP_BITS(4), .WINDOW(256), .SAMPLE_W(8), .ADDR_W(17), .NUM_SAMPLES(131072)
    ) dut_b (
        .clock_i(clk), .reset_i(reset_n), .enable_i(en_b), .done_o(done_b), .mic_clk_o(mic_b),
        .mic_data_i(dat_b), .sample_o(sample_b), .sample_index_o(index_b), .sample_valid_o(valid_b)
    );

    // Bit k of the PDM stream for a given pattern.
    function automatic logic bit_of(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k % 2) == 0;
            default: return rnd[k % 64];
        endcase
    endfunction

    // Word w = ones in bits [wb + w*win, wb + (w+1)*win), clipped to the word range.
    function automatic int model_word(input int mode, input int wb, input int win, input int sw, input int w);
        int s = 0;
        for (int k = wb + w * win; k < wb + (w + 1) * win; k++) s += int'(bit_of(mode, k));
        if (s > (1 << sw) - 1) s = (1 << sw) - 1;
        return s;
    endfunction

    // Mic presents a new bit after each falling mic clock edge.
    always @(negedge mic_a) begin
        #1;
        bitno_a = bitno_a + 1;
        dat_a   = bit_of(mode_a, bitno_a);
    end

    always @(negedge mic_b) begin
        #1;
        bitno_b = bitno_b + 1;
        dat_b   = bit_of(mode_b, bitno_b);
    end

    task automatic test_reset();
        reset_n = 1'b0; en_a = 1'b1; en_b = 1'b1; dat_a = 1'b0; dat_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dat_a = ~dat_a; dat_b = ~dat_b;
        end
        checks++; if ({done_a, mic_a, valid_a, sample_a, index_a} !== 15'd0) begin
            failures++; $display("FAIL reset_a outputs got=%h exp=0", {done_a, mic_a, valid_a, sample_a, index_a});
        end
        checks++; if ({done_b, mic_b, valid_b, sample_b, index_b} !== 28'd0) begin
            failures++; $display("FAIL reset_b outputs got=%h exp=0", {done_b, mic_b, valid_b, sample_b, index_b});
        end
        en_a = 1'b0; en_b = 1'b0; reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (mic_a !== 1'b0 || done_a !== 1'b0) begin
                failures++; $display("FAIL reset_release_idle cyc=%0d mic=%b done=%b exp=0,0", i, mic_a, done_a);
            end
        end
    endtask

    // Full 3-word clip on instance A, cycle-exact from the first WARMUP cycle, then release.
    task automatic run_a(input int mode, input string tag);
        int w = 0;
        logic exp_valid, exp_done, exp_mic;
        @(negedge clk);
        mode_a = mode; bitno_a = 0; dat_a = bit_of(mode, 0); reset_n = 1'b1; en_a = 1'b1;
        for (int n = 0; n < 130; n++) begin
            @(posedge clk); @(negedge clk);
            exp_valid = (n == 48) || (n == 80) || (n == 112);
            exp_done  = (n >= 113);
            exp_mic   = (n >= 113) ? 1'b0 : (((n / 2) % 2) == 1);
            checks++; if (valid_a !== exp_valid) begin
                failures++; $display("FAIL %s valid n=%0d got=%b exp=%b", tag, n, valid_a, exp_valid);
            end
            checks++; if (mic_a !== exp_mic) begin
                failures++; $display("FAIL %s mic_clk n=%0d got=%b exp=%b", tag, n, mic_a, exp_mic);
            end
            checks++; if (done_a !== exp_done) begin
                failures++; $display("FAIL %s done n=%0d got=%b exp=%b", tag, n, done_a, exp_done);
            end
            if (exp_valid) begin
                checks++; if (int'(sample_a) !== model_word(mode, 4, 8, 8, w)) begin
                    failures++; $display("FAIL %s sample w=%0d got=%0d exp=%0d", tag, w, sample_a, model_word(mode, 4, 8, 8, w));
                end
                checks++; if (int'(index_a) !== w) begin
                    failures++; $display("FAIL %s index w=%0d got=%0d exp=%0d", tag, w, index_a, w);
                end
                w++;
            end
        end
        checks++; if (int'(sample_a) !== model_word(mode, 4, 8, 8, 2) || index_a !== 4'd2) begin
            failures++; $display("FAIL %s done_hold got=%0d/%0d exp=%0d/2", tag, sample_a, index_a, model_word(mode, 4, 8, 8, 2));
        end
        en_a = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (done_a !== 1'b0 || mic_a !== 1'b0) begin
            failures++; $display("FAIL %s release done=%b mic=%b exp=0,0", tag, done_a, mic_a);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        @(negedge clk);
        mode_a = 1; bitno_a = 0; dat_a = 1'b1; en_a = 1'b1;
        for (int n = 0; n <= 30; n++) @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++; if (valid_a !== 1'b0 || mic_a !== 1'b0 || done_a !== 1'b0) begin
                failures++; $display("FAIL abort_idle i=%0d valid=%b mic=%b done=%b exp=0,0,0", i, valid_a, mic_a, done_a);
            end
        end
        run_a(1, "restart");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        mode_a = 1; bitno_a = 0; dat_a = 1'b1; en_a = 1'b1;
        for (int n = 0; n <= 60; n++) @(negedge clk);
        checks++; if (index_a !== 4'd1) begin
            failures++; $display("FAIL pre_reset index got=%0d exp=1", index_a);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({done_a, mic_a, valid_a} !== 3'b000) begin
            failures++; $display("FAIL async_reset ctl got=%b exp=000", {done_a, mic_a, valid_a});
        end
        checks++; if (sample_a !== 8'd0 || index_a !== 4'd0) begin
            failures++; $display("FAIL async_reset data got=%0d/%0d exp=0/0", sample_a, index_a);
        end
        run_a(3, "recover_random");
    endtask

    // First two words of instance B for one pattern.
    task automatic run_b(input int mode, input int expv, input string tag);
        int first_n = -1, second_n = -1;
        int s0 = -1, s1 = -1, i0 = -1, i1 = -1;
        @(negedge clk);
        mode_b = mode; bitno_b = 0; dat_b = bit_of(mode, 0); en_b = 1'b1;
        for (int n = 0; n < 2100; n++) begin
            @(posedge clk); @(negedge clk);
            if (valid_b === 1'b1) begin
                if (first_n < 0) begin
                    first_n = n; s0 = int'(sample_b); i0 = int'(index_b);
                end else if (second_n < 0) begin
                    second_n = n; s1 = int'(sample_b); i1 = int'(index_b);
                end
            end
        end
        checks++; if (first_n !== 1040 || i0 !== 0) begin
            failures++; $display("FAIL %s first_pulse cyc=%0d idx=%0d exp=1040/0", tag, first_n, i0);
        end
        checks++; if (s0 !== expv) begin
            failures++; $display("FAIL %s word0 got=%0d exp=%0d", tag, s0, expv);
        end
        checks++; if (second_n !== 2064 || i1 !== 1 || s1 !== expv) begin
            failures++; $display("FAIL %s word1 cyc=%0d idx=%0d val=%0d exp=2064/1/%0d", tag, second_n, i1, s1, expv);
        end
        en_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rnd[i] = 1'($urandom_range(0, 1));
        test_reset();
        run_a(1, "latency_ones");
        run_a(3, "random");
        test_abort();
        test_async_reset();
        run_b(1, 255, "sat_ones");
        run_b(2, 128, "alt_1010");
        run_b(0, 0, "zeros");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
